// File: rtl/rf_conv_classifier.sv
// rf_conv_classifier
// ------------------------------------------------------------------------
// Frame-based receptive-field convolution and spike classifier. On start,
// a frame of N_FIELD K-bit fields is latched together with a K-word kernel
// and a class template. Each field is convolved against the kernel in turn.
// The result is streamed out as two bytes (high, then low) over a
// valid/ready handshake, and threshold spikes are raised. Per-class scores
// count the high spikes that land on the class template. After the last
// field, a one-cycle decide step picks the best class, with the lowest
// index winning ties.
//
// Optional feature: define RFC_LO_CNT_EN to build the per-frame spike_lo
// tally on lo_count. Without it, lo_count is tied to zero.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   start         : frame request (only sampled in IDLE)
//   code          : frame code, field 0 is the most significant K-bit slice
//   weight        : kernel, word j = weight[j*WW +: WW]
//   class_mask    : bit c*N_FIELD+f set -> field f belongs to class c
//   out_valid/out_data/out_ready : byte stream of conv results
//   spike_hi, spike_lo, ref_spike: per-field spikes during byte transfer
//   busy, done    : frame activity and end-of-frame pulse
//   class_id, class_onehot, no_match : decision, held until next decide
//   lo_count      : spike_lo tally (RFC_LO_CNT_EN only)
// ------------------------------------------------------------------------
module rf_conv_classifier #(
    parameter int N_FIELD = 16,
    parameter int K       = 4,
    parameter int WW      = 8,
    parameter int N_CLASS = 4,
    parameter int TH_HI   = 128,
    parameter int TH_LO   = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N_FIELD*K-1:0]         code,
    input  logic [K*WW-1:0]              weight,
    input  logic [N_CLASS*N_FIELD-1:0]   class_mask,
    output logic                         out_valid,
    output logic [7:0]                   out_data,
    input  logic                         out_ready,
    output logic                         spike_hi,
    output logic                         spike_lo,
    output logic                         ref_spike,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_CLASS)-1:0]   class_id,
    output logic [N_CLASS-1:0]           class_onehot,
    output logic                         no_match,
    output logic [$clog2(N_FIELD+1)-1:0] lo_count
);

    localparam int CW  = WW + $clog2(K + 1);
    localparam int SW  = $clog2(N_FIELD + 1);
    localparam int FW  = (N_FIELD > 1) ? $clog2(N_FIELD) : 1;
    localparam int CIW = $clog2(N_CLASS);

    generate
        if (CW > 16) begin : g_cw_too_wide
            $error("rf_conv_classifier: conv width WW+clog2(K+1) exceeds 16 bits");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SEND_H,
        SEND_L,
        DECIDE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [N_FIELD*K-1:0]       code_r;
    logic [K*WW-1:0]            weight_r;
    logic [N_CLASS*N_FIELD-1:0] mask_r;
    logic [FW-1:0]              field_idx;
    logic [CW-1:0]              conv_r;
    logic                       hi_r;
    logic                       lo_r;
    logic [SW-1:0]              score [N_CLASS];
    logic [CIW-1:0]             class_id_r;
    logic [N_CLASS-1:0]         onehot_r;
    logic                       no_match_r;

    logic [K-1:0]   cur_field;
    logic [CW-1:0]  conv_next;
    logic [15:0]    conv_ext;
    logic [SW-1:0]  best_score;
    logic [CIW-1:0] best_id;
    logic           sending;
    logic           last_field;

    assign last_field = (field_idx == FW'(N_FIELD - 1));
    assign conv_ext   = 16'(conv_r);
    assign sending    = (state == SEND_H) || (state == SEND_L);

    // Select the current field (field 0 sits at the top of the code word)
    // and form the kernel dot product. Field bit K-1-j gates weight word j.
    always_comb begin
        cur_field = code_r[(N_FIELD - 1 - int'(field_idx)) * K +: K];
        conv_next = '0;
        for (int j = 0; j < K; j++) begin
            if (cur_field[K-1-j]) begin
                conv_next = conv_next + CW'(weight_r[j*WW +: WW]);
            end
        end
    end

    // Strictly-greater comparison keeps the lowest index on ties. An
    // all-zero score set leaves best_id at 0, which is the no-match answer.
    always_comb begin
        best_score = '0;
        best_id    = '0;
        for (int c = 0; c < N_CLASS; c++) begin
            if (score[c] > best_score) begin
                best_score = score[c];
                best_id    = CIW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs. The byte states only
    // advance on a completed handshake. Out_valid is already high in those
    // states, so out_ready alone decides.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CONV;
            end
            CONV: begin
                state_next = SEND_H;
            end
            SEND_H: begin
                out_valid = 1'b1;
                out_data  = conv_ext[15:8];
                if (out_ready) state_next = SEND_L;
            end
            SEND_L: begin
                out_valid = 1'b1;
                out_data  = conv_ext[7:0];
                if (out_ready) state_next = last_field ? DECIDE : CONV;
            end
            DECIDE: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ref_spike = sending;
    assign spike_hi  = hi_r & sending;
    assign spike_lo  = lo_r & sending;

    // Frame datapath: latch on start, register conv and spike flags in
    // CONV, score on the low-byte handshake, and capture the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r     <= '0;
            weight_r   <= '0;
            mask_r     <= '0;
            field_idx  <= '0;
            conv_r     <= '0;
            hi_r       <= 1'b0;
            lo_r       <= 1'b0;
            class_id_r <= '0;
            onehot_r   <= '0;
            no_match_r <= 1'b0;
            for (int c = 0; c < N_CLASS; c++) begin
                score[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        code_r    <= code;
                        weight_r  <= weight;
                        mask_r    <= class_mask;
                        field_idx <= '0;
                        for (int c = 0; c < N_CLASS; c++) begin
                            score[c] <= '0;
                        end
                    end
                end
                CONV: begin
                    conv_r <= conv_next;
                    hi_r   <= (32'(conv_next) > 32'(TH_HI));
                    lo_r   <= (32'(conv_next) < 32'(TH_LO));
                end
                SEND_L: begin
                    if (out_ready) begin
                        for (int c = 0; c < N_CLASS; c++) begin
                            if (hi_r && mask_r[c*N_FIELD + int'(field_idx)]) begin
                                score[c] <= score[c] + SW'(1);
                            end
                        end
                        if (!last_field) begin
                            field_idx <= field_idx + FW'(1);
                        end
                    end
                end
                DECIDE: begin
                    class_id_r <= best_id;
                    onehot_r   <= N_CLASS'(1) << best_id;
                    no_match_r <= (best_score == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign class_id     = class_id_r;
    assign class_onehot = onehot_r;
    assign no_match     = no_match_r;

`ifdef RFC_LO_CNT_EN
    logic [SW-1:0] lo_cnt;

    // Tally of low-spike fields in the current frame, cleared on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_cnt <= '0;
        end else if (state == IDLE && start) begin
            lo_cnt <= '0;
        end else if (state == SEND_L && out_ready && lo_r) begin
            lo_cnt <= lo_cnt + SW'(1);
        end
    end

    assign lo_count = lo_cnt;
`else
    assign lo_count = '0;
`endif

endmodule

// File: tb/tb_rf_conv_classifier.sv
// tb_rf_conv_classifier
// ------------------------------------------------------------------------
// Self-checking bench for rf_conv_classifier at default parameters.
// Frames are driven with directed and $urandom content. Every byte, spike,
// and decision is compared against a reference model that evaluates the
// convolution and scoring rules arithmetically, per frame.
// ------------------------------------------------------------------------
module tb_rf_conv_classifier;

    localparam int N_FIELD = 16;
    localparam int K       = 4;
    localparam int WW      = 8;
    localparam int N_CLASS = 4;
    localparam int TH_HI   = 128;
    localparam int TH_LO   = 20;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic [N_FIELD*K-1:0]       code;
    logic [K*WW-1:0]            weight;
    logic [N_CLASS*N_FIELD-1:0] class_mask;
    logic                       out_valid;
    logic [7:0]                 out_data;
    logic                       out_ready;
    logic                       spike_hi;
    logic                       spike_lo;
    logic                       ref_spike;
    logic                       busy;
    logic                       done;
    logic [1:0]                 class_id;
    logic [N_CLASS-1:0]         class_onehot;
    logic                       no_match;
    logic [4:0]                 lo_count;

    int n_cmp = 0;
    int n_err = 0;

    int exp_conv [N_FIELD];
    int exp_score [N_CLASS];
    int exp_lo;
    int exp_id;
    int exp_nomatch;

    always #5 clk = ~clk;

    rf_conv_classifier #(
        .N_FIELD(N_FIELD), .K(K), .WW(WW), .N_CLASS(N_CLASS),
        .TH_HI(TH_HI), .TH_LO(TH_LO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .code(code), .weight(weight),
        .class_mask(class_mask), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .spike_hi(spike_hi), .spike_lo(spike_lo),
        .ref_spike(ref_spike), .busy(busy), .done(done), .class_id(class_id),
        .class_onehot(class_onehot), .no_match(no_match), .lo_count(lo_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_out_valid"},    out_valid,    0);
        checkOutput({tag, "_out_data"},     out_data,     0);
        checkOutput({tag, "_spike_hi"},     spike_hi,     0);
        checkOutput({tag, "_spike_lo"},     spike_lo,     0);
        checkOutput({tag, "_ref_spike"},    ref_spike,    0);
        checkOutput({tag, "_busy"},         busy,         0);
        checkOutput({tag, "_done"},         done,         0);
        checkOutput({tag, "_class_id"},     class_id,     0);
        checkOutput({tag, "_class_onehot"}, class_onehot, 0);
        checkOutput({tag, "_no_match"},     no_match,     0);
        checkOutput({tag, "_lo_count"},     lo_count,     0);
    endtask

    // Reference model: per-field conv by bit-weighted sum, scores by
    // template hits on high spikes, then argmax with first-index ties.
    function automatic void buildModel(input logic [N_FIELD*K-1:0] c,
                                       input logic [K*WW-1:0] w,
                                       input logic [N_CLASS*N_FIELD-1:0] m);
        int fld;
        int best;
        exp_lo = 0;
        for (int cl = 0; cl < N_CLASS; cl++) exp_score[cl] = 0;
        for (int f = 0; f < N_FIELD; f++) begin
            fld = int'((c >> ((N_FIELD - 1 - f) * K)) & 64'hF);
            exp_conv[f] = 0;
            for (int j = 0; j < K; j++) begin
                if (((fld >> (K - 1 - j)) & 1) == 1)
                    exp_conv[f] += int'((w >> (j * WW)) & 32'hFF);
            end
            if (exp_conv[f] > TH_HI) begin
                for (int cl = 0; cl < N_CLASS; cl++)
                    if (m[cl*N_FIELD + f]) exp_score[cl]++;
            end
            if (exp_conv[f] < TH_LO) exp_lo++;
        end
        best = 0;
        exp_id = 0;
        for (int cl = 0; cl < N_CLASS; cl++) begin
            if (exp_score[cl] > best) begin
                best = exp_score[cl];
                exp_id = cl;
            end
        end
        exp_nomatch = (best == 0) ? 1 : 0;
    endfunction

    // Runs one frame. mode 0: random out_ready, random start and input
    // churn; mode 1: out_ready always high; mode 2: 10-cycle stall on the
    // first high byte. abort_byte >= 0 resets once that many bytes are taken.
    task automatic applyStimulus(input logic [N_FIELD*K-1:0] c,
                                 input logic [K*WW-1:0] w,
                                 input logic [N_CLASS*N_FIELD-1:0] m,
                                 input int mode, input int abort_byte);
        int bytes, last_hs, stall_left, fidx, eb, exp_lo_out;
        bit done_seen, prev_stall;
        logic [7:0] prev_data;
        buildModel(c, w, m);
`ifdef RFC_LO_CNT_EN
        exp_lo_out = exp_lo;
`else
        exp_lo_out = 0;
`endif
        bytes = 0; last_hs = 0; stall_left = 10;
        done_seen = 0; prev_stall = 0; prev_data = 8'h00;
        @(negedge clk);
        code = c; weight = w; class_mask = m; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        code = {$urandom, $urandom};
        weight = $urandom;
        class_mask = {$urandom, $urandom};
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (done) begin
                done_seen = 1;
                checkOutput("done_latency", cyc - last_hs, 2);
                checkOutput("byte_count", bytes, 2 * N_FIELD);
                checkOutput("class_id", class_id, exp_id);
                checkOutput("class_onehot", class_onehot, 32'd1 << exp_id);
                checkOutput("no_match", no_match, exp_nomatch);
                checkOutput("lo_count", lo_count, exp_lo_out);
                start = 1'b0;
                break;
            end
            checkOutput("busy", busy, 1);
            if (prev_stall) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, prev_data);
            end
            if (out_valid) begin
                fidx = bytes / 2;
                eb = (bytes % 2 == 0) ? ((exp_conv[fidx] >> 8) & 255) : (exp_conv[fidx] & 255);
                checkOutput("out_data", out_data, eb);
                checkOutput("ref_spike", ref_spike, 1);
                checkOutput("spike_hi", spike_hi, (exp_conv[fidx] > TH_HI) ? 1 : 0);
                checkOutput("spike_lo", spike_lo, (exp_conv[fidx] < TH_LO) ? 1 : 0);
            end else begin
                checkOutput("ref_spike_idle", ref_spike, 0);
                checkOutput("spike_hi_idle", spike_hi, 0);
                checkOutput("spike_lo_idle", spike_lo, 0);
            end
            if (abort_byte >= 0 && out_valid && bytes == abort_byte) begin
                out_ready = 1'b0;
                rst = 1'b1;
                start = 1'b1;
                @(negedge clk);
                checkResetOutputs("abort");
                rst = 1'b0;
                start = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    checkOutput("no_done_after_abort", done, 0);
                end
                checkOutput("idle_after_abort", busy, 0);
                return;
            end
            case (mode)
                0: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    start = ($urandom_range(0, 7) == 0);
                    code = {$urandom, $urandom};
                    weight = $urandom;
                    class_mask = {$urandom, $urandom};
                end
                2: begin
                    if (out_valid && bytes == 0 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                bytes++;
                last_hs = cyc;
            end
            @(negedge clk);
        end
        if (!done_seen) begin
            checkOutput("frame_timeout", 0, 1);
        end else begin
            @(negedge clk);
            checkOutput("busy_after_done", busy, 0);
            checkOutput("done_one_cycle", done, 0);
            checkOutput("class_id_hold", class_id, exp_id);
            if (mode == 2) checkOutput("stall_cycles_used", stall_left, 0);
        end
    endtask

    initial begin
        logic [N_CLASS*N_FIELD-1:0] m24;
        logic [N_FIELD*K-1:0]       c24;
        rst = 1'b1; start = 1'b1; out_ready = 1'b1;
        code = '0; weight = '0; class_mask = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        $display("[TB] all-0xF frame");
        applyStimulus({N_FIELD{4'hF}}, 32'h3132_3130, '1, 1, -1);

        $display("[TB] alternating 0x8 / 0x0 fields");
        applyStimulus({(N_FIELD/2){8'h80}}, 32'h3132_3130, {$urandom, $urandom}, 1, -1);

        $display("[TB] class 2 template");
        m24 = '0;
        c24 = '0;
        foreach (m24[i]) begin
            if (i == 2*N_FIELD + 5 || i == 2*N_FIELD + 8 ||
                i == 2*N_FIELD + 9 || i == 2*N_FIELD + 12) m24[i] = 1'b1;
        end
        for (int f = 0; f < N_FIELD; f++) begin
            if (f == 5 || f == 8 || f == 9 || f == 12)
                c24[(N_FIELD - 1 - f) * K +: K] = 4'hF;
        end
        applyStimulus(c24, 32'h3132_3130, m24, 1, -1);
        checkOutput("class2_id", class_id, 2);
        checkOutput("class2_onehot", class_onehot, 4'b0100);

        $display("[TB] stalled high byte");
        applyStimulus({$urandom, $urandom}, 32'h3132_3130, '1, 2, -1);

        $display("[TB] all-zero code");
        applyStimulus('0, 32'h3132_3130, '1, 0, -1);
        checkOutput("zero_no_match", no_match, 1);
        checkOutput("zero_class_id", class_id, 0);

        $display("[TB] reset in field 7 low byte, then a full frame");
        applyStimulus({$urandom, $urandom}, 32'h3132_3130, '1, 0, 15);
        applyStimulus({$urandom, $urandom}, 32'h3132_3130, {$urandom, $urandom}, 0, -1);

        $display("[TB] random frames");
        for (int t = 0; t < 6; t++) begin
            applyStimulus({$urandom, $urandom}, $urandom, {$urandom, $urandom}, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
